// File: rtl/gpu_pkg.sv
// Shared constants and types for the 2D GPU render path.
// Used by ahb_pixel_writer and its pixel_fifo.
package gpu_pkg;
   localparam int XWIDTH    = 320;
   localparam int YHEIGHT   = 240;
   localparam int PIXWIDTH  = 24;
   localparam int ADDRWIDTH = 24;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_NONSEQ = 2'b10
   } htrans_t;

   typedef enum logic [1:0] {
      RUN,
      SWAP_PEND,
      SWAP
   } pw_state_t;
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with full/empty/count status; DEPTH must be a power of two.
// Read data is the current head entry (show-ahead).
module pixel_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr;
   logic             rd;

   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
   assign wr    = push && !full;
   assign rd    = pop && !empty;
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (rd) rd_ptr <= rd_ptr + AW'(1);
         unique case ({wr, rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/ahb_pixel_writer.sv
// AHB-Lite write master for rasterizer pixels into a double-buffered frame buffer.
// Optional PIXEL_WRITER_CLIP_EN drops out-of-range pixels after the handshake.
module ahb_pixel_writer #(
   parameter int XWIDTH    = gpu_pkg::XWIDTH,
   parameter int YHEIGHT   = gpu_pkg::YHEIGHT,
   parameter int PIXWIDTH  = gpu_pkg::PIXWIDTH,
   parameter int ADDRWIDTH = gpu_pkg::ADDRWIDTH,
   parameter logic [ADDRWIDTH-1:0] BASE_ADDR = '0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   input  logic [8:0]           pix_x,
   input  logic [7:0]           pix_y,
   input  logic [PIXWIDTH-1:0]  pix_color,
   input  logic                 frame_done,
   output logic                 swap_done,
   output logic                 back_sel,
   output logic [ADDRWIDTH-1:0] HADDR,
   output logic [1:0]           HTRANS,
   output logic                 HWRITE,
   output logic [2:0]           HSIZE,
   output logic [PIXWIDTH-1:0]  HWDATA,
   input  logic                 HREADY,
   input  logic                 HRESP,
   output logic                 bus_error
);
   import gpu_pkg::*;

   localparam int EW = ADDRWIDTH + PIXWIDTH;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   pw_state_t            state;
   logic [EW-1:0]        head;
   logic [CW-1:0]        count;
   logic                 full;
   logic                 empty;
   logic                 accept;
   logic                 push;
   logic                 pop;
   logic                 nonseq;
   logic                 dval;
   logic                 err_idle;
   logic [ADDRWIDTH-1:0] row;
   logic [ADDRWIDTH-1:0] addr;

   assign pix_ready = !rst && !full && state != SWAP_PEND;
   assign accept    = pix_valid && pix_ready;
   assign row  = ADDRWIDTH'(pix_y) + (back_sel ? ADDRWIDTH'(YHEIGHT) : '0);
   assign addr = BASE_ADDR + row * ADDRWIDTH'(XWIDTH) + ADDRWIDTH'(pix_x);

`ifdef PIXEL_WRITER_CLIP_EN
   assign push = accept && (32'(pix_x) < XWIDTH) && (32'(pix_y) < YHEIGHT);
`else
   assign push = accept;
`endif

   // err_idle blanks the address phase during the second error cycle
   assign nonseq = !empty && !err_idle;
   assign pop    = nonseq && HREADY;
   assign HTRANS = nonseq ? HT_NONSEQ : HT_IDLE;
   assign HWRITE = nonseq;
   assign HSIZE  = 3'b010;
   assign HADDR  = nonseq ? head[EW-1 -: ADDRWIDTH] : '0;

   pixel_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({addr, pix_color}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         HWDATA    <= '0;
         dval      <= 1'b0;
         err_idle  <= 1'b0;
         bus_error <= 1'b0;
      end else begin
         if (pop) HWDATA <= head[PIXWIDTH-1:0];
         if (HREADY) dval <= pop;
         err_idle <= dval && HRESP && !HREADY;
         if (dval && HRESP) bus_error <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         back_sel  <= 1'b0;
         swap_done <= 1'b0;
      end else begin
         swap_done <= 1'b0;
         unique case (state)
            RUN: if (frame_done) state <= SWAP_PEND;
            // swap on the edge that retires the last data phase
            SWAP_PEND: if (count == '0 && (!dval || HREADY)) begin
               state     <= SWAP;
               back_sel  <= !back_sel;
               swap_done <= 1'b1;
            end
            SWAP:    state <= RUN;
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: doc/ahb_pixel_writer.md
# ahb_pixel_writer

Render-side AHB-Lite write master for the 2D GPU. It accepts (x, y, color) pixel writes from the rasterizer over a valid/ready handshake and buffers them in a small FIFO. Each pixel becomes a single pipelined AHB-Lite write into the double-buffered 320x240 frame buffer, which holds two 240-row buffers stacked one above the other. On a frame-done request it drains all pending writes, then toggles the back-buffer select.

## Interface
Parameters:
- XWIDTH, 320, pixels per row
- YHEIGHT, 240, rows per buffer (frame buffer holds 2*YHEIGHT rows)
- PIXWIDTH, 24, RGB888 pixel width
- ADDRWIDTH, 24, AHB address width
- BASE_ADDR, 0, address of pixel (0,0) of buffer 0
- FIFO_DEPTH, 4, pixel FIFO entries (power of two)

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- pix_valid  in  1  rasterizer presents a pixel
- pix_ready  out  1  pixel accepted on an edge where valid && ready
- pix_x  in  9  column
- pix_y  in  8  row within the buffer
- pix_color  in  PIXWIDTH  RGB, [23:16]=R, [15:8]=G, [7:0]=B
- frame_done  in  1  one-cycle pulse that ends the current frame
- swap_done  out  1  one-cycle pulse when back_sel toggles
- back_sel  out  1  buffer being written; 0 = rows 0..239, 1 = rows 240..479
- HADDR  out  ADDRWIDTH  AHB address
- HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10 only
- HWRITE  out  1  1 during NONSEQ, 0 otherwise
- HSIZE  out  3  fixed 3'b010
- HWDATA  out  PIXWIDTH  write data, driven in the data phase
- HREADY  in  1  slave ready
- HRESP  in  1  1 = ERROR
- bus_error  out  1  sticky until reset; set by any ERROR response

## Operation
- Address is computed on FIFO entry: BASE_ADDR + (pix_y + back_sel*YHEIGHT)*XWIDTH + pix_x, in ADDRWIDTH-bit unsigned arithmetic. The maximum offset, 153599, fits in 18 bits.
- The FIFO stores {addr, color}.
- pix_ready = !full && state != SWAP_PEND.
  - When the FIFO is full, ready is low even if a pop occurs in the same cycle.
- The FSM has three states:
  - RUN: issue transfers from the FIFO head.
  - SWAP_PEND: frame_done has been seen; stop accepting pixels and drain.
  - SWAP: toggle back_sel and pulse swap_done for one cycle, then return to RUN.
- RUN to SWAP_PEND on a frame_done pulse.
- SWAP_PEND to SWAP when the FIFO is empty and no data phase is outstanding.
- frame_done and an accepted pixel in the same cycle: the pixel belongs to the old frame.
- frame_done while already in SWAP_PEND or SWAP is ignored.
- AHB pipeline:
  - HTRANS=NONSEQ whenever the FIFO is non-empty. HADDR is taken from the FIFO head.
  - On an edge with HREADY=1, the head is popped and its color is latched into HWDATA for the data phase.
  - Back-to-back transfers overlap: address phase N+1 runs during data phase N.
  - HREADY=0 stalls both phases. HADDR, HTRANS and HWDATA are held.
- HRESP=ERROR: bus_error is set. The transfer is not retried.
  - The first ERROR cycle forces HTRANS=IDLE for one cycle, per the AHB-Lite two-cycle response. The head is not popped that cycle.

## Timing
- Pixel accepted at edge N: NONSEQ with its address during cycle N+1. HWDATA is valid from edge N+1 (zero wait states), and the data phase completes at edge N+2.
- Throughput is 1 pixel/cycle with HREADY=1 and pix_valid held high.
- swap_done is high for the one cycle after the data phase of the last drained write completes.
- Reset values:
  - pix_ready=0 during reset, 1 on the first cycle after reset.
  - HTRANS=IDLE, HWRITE=0, HADDR=0, HWDATA=0.
  - back_sel=0, swap_done=0, bus_error=0.
  - FIFO empty, state RUN.
- Reset mid-transfer abandons all queued and in-flight pixels. The bus is IDLE from the reset edge onward.

## Configuration
- PIXEL_WRITER_CLIP_EN defined: pixels with pix_x>=XWIDTH or pix_y>=YHEIGHT are accepted (ready handshake completes) but discarded. They never enter the FIFO.
- Undefined: no check is made; the address is computed as-is.

## Structure
- gpu_pkg: XWIDTH, YHEIGHT, PIXWIDTH, ADDRWIDTH constants; htrans_t enum; pw_state_t enum {RUN, SWAP_PEND, SWAP}.
- One sub-module: pixel_fifo. It is synchronous, parameterized in width and depth, with full, empty and count outputs. The instance in this block has width ADDRWIDTH+PIXWIDTH.

## Test plan
- Reset, back_sel=0, push (x=5, y=2, color=24'hFF0000) with HREADY=1 -> NONSEQ, HADDR=645 in the cycle after acceptance; HWDATA=24'hFF0000 in the following cycle.
- frame_done pulse, then push (x=0, y=0) -> swap_done pulses once, back_sel=1, HADDR=76800. Push (x=319, y=239) -> HADDR=153599.
- Push 6 pixels back-to-back with HREADY=0 -> pix_ready drops after 4 accepted. HADDR holds the first address until HREADY=1; all 6 then complete in order.
- frame_done with 3 pixels queued -> pix_ready=0 until swap_done. swap_done arrives exactly one cycle after the third data phase completes.
- With PIXEL_WRITER_CLIP_EN, push x=320 -> handshake completes, HTRANS stays IDLE. Without it -> HADDR=320.
- HRESP=ERROR on a data phase -> bus_error=1 and a one-cycle IDLE. Assert rst mid-burst -> all outputs return to reset values immediately.
